// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment bit positions and the hex glyph table.
package seg_pkg;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    localparam int unsigned GLYPH_W = 7;
    localparam int unsigned SEG_W   = 8;

    // Active-high {g,f,e,d,c,b,a} glyphs for 0..F
    localparam logic [GLYPH_W-1:0] HEXSEG_TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-high 7-segment glyph decoder.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0]         nibble,
    output logic [GLYPH_W-1:0] seg_c
);

    assign seg_c = HEXSEG_TBL[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner with double-buffered display set, PWM
// brightness, blink, blanking and leading-zero suppression.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS         = 8,
    parameter int unsigned SCAN_DIV       = 50_000,
    parameter int unsigned BLINK_FRAMES   = 250,
    parameter int unsigned SEL_ACTIVE_LOW = 0,
    parameter int unsigned SEG_ACTIVE_LOW = 1
)
(
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [4*DIGITS-1:0]   Disp_Data,
    input  logic [DIGITS-1:0]     Dp_Mask,
    input  logic [DIGITS-1:0]     Blank_Mask,
    input  logic [DIGITS-1:0]     Blink_Mask,
    input  logic [3:0]            Bright,
    input  logic                  Lz_En,
    input  logic                  Load,
    output logic [DIGITS-1:0]     SEL,
    output logic [SEG_W-1:0]      SEG,
    output logic                  Frame_Done
);

    localparam int unsigned PWM_DIV = SCAN_DIV / 16;
    localparam int unsigned SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned SUB_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned DATA_W  = 4 * DIGITS;

    localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [SEG_W-1:0]  SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

    logic [SLOT_W-1:0] slot_cnt;
    logic [SUB_W-1:0]  sub_cnt;
    logic [3:0]        phase;
    logic [DIG_W-1:0]  digit_idx;
    logic [FRM_W-1:0]  frame_cnt;
    logic              blink_ph;

    logic [DATA_W-1:0] sh_data,  act_data;
    logic [DIGITS-1:0] sh_dp,    act_dp;
    logic [DIGITS-1:0] sh_blank, act_blank;
    logic [DIGITS-1:0] sh_blink, act_blink;
    logic [3:0]        sh_bright, act_bright;
    logic              sh_lz,    act_lz;

    logic slot_wrap, sub_wrap, fe;

    assign slot_wrap = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
    assign sub_wrap  = (sub_cnt == SUB_W'(PWM_DIV - 1));
    assign fe        = slot_wrap && (digit_idx == DIG_W'(DIGITS - 1));

    // Slot, PWM phase, digit and blink-frame counters
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            slot_cnt  <= '0;
            sub_cnt   <= '0;
            phase     <= '0;
            digit_idx <= '0;
            frame_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            if (slot_wrap) begin
                slot_cnt  <= '0;
                sub_cnt   <= '0;
                phase     <= '0;
                digit_idx <= (digit_idx == DIG_W'(DIGITS - 1)) ? '0 : digit_idx + DIG_W'(1);
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
                if (sub_wrap) begin
                    sub_cnt <= '0;
                    phase   <= phase + 4'd1;
                end else begin
                    sub_cnt <= sub_cnt + SUB_W'(1);
                end
            end
            if (fe) begin
                if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    frame_cnt <= frame_cnt + FRM_W'(1);
                end
            end
        end
    end

    // Shadow captures on Load; active set commits only at frame end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sh_data    <= '0;
            sh_dp      <= '0;
            sh_blank   <= '1;
            sh_blink   <= '0;
            sh_bright  <= '0;
            sh_lz      <= 1'b0;
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= '1;
            act_blink  <= '0;
            act_bright <= '0;
            act_lz     <= 1'b0;
        end else begin
            if (Load) begin
                sh_data   <= Disp_Data;
                sh_dp     <= Dp_Mask;
                sh_blank  <= Blank_Mask;
                sh_blink  <= Blink_Mask;
                sh_bright <= Bright;
                sh_lz     <= Lz_En;
            end
            if (fe) begin
                act_data   <= Load ? Disp_Data  : sh_data;
                act_dp     <= Load ? Dp_Mask    : sh_dp;
                act_blank  <= Load ? Blank_Mask : sh_blank;
                act_blink  <= Load ? Blink_Mask : sh_blink;
                act_bright <= Load ? Bright     : sh_bright;
                act_lz     <= Load ? Lz_En      : sh_lz;
            end
        end
    end

    logic [3:0]         cur_nib;
    logic [GLYPH_W-1:0] cur_hex;
    logic               cur_dp, cur_blank, cur_blink, cur_supp, zero_run, dark_c;
    logic [DIGITS-1:0]  sel_c;
    logic [SEG_W-1:0]   seg_c;

    seg_hex_decode u_dec (
        .nibble (cur_nib),
        .seg_c  (cur_hex)
    );

    // Select the current digit's attributes and decide whether it is dark
    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        cur_supp  = 1'b0;
        zero_run  = 1'b1;
        sel_c     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (act_data[4*i +: 4] == 4'h0);
            if (DIG_W'(i) == digit_idx) begin
                cur_nib   = act_data[4*i +: 4];
                cur_dp    = act_dp[i];
                cur_blank = act_blank[i];
                cur_blink = act_blink[i];
                cur_supp  = act_lz & zero_run & (i != 0);
                sel_c[i]  = 1'b1;
            end
        end
        dark_c = (slot_cnt == '0) | cur_blank | cur_supp
               | (cur_blink & blink_ph) | (phase > act_bright);
        seg_c  = {cur_dp, cur_hex};
        if (dark_c) begin
            sel_c = '0;
            seg_c = '0;
        end
    end

    // Output register with pin polarity applied last
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            SEL        <= SEL_OFF;
            SEG        <= SEG_OFF;
            Frame_Done <= 1'b0;
        end else begin
            SEL        <= sel_c ^ SEL_OFF;
            SEG        <= seg_c ^ SEG_OFF;
            Frame_Done <= fe;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: time-based reference model, vector
// table and directed multi-cycle sequences.
module tb_seg_scan_ctrl;

    localparam int unsigned DIGITS       = 4;
    localparam int unsigned SCAN_DIV     = 32;
    localparam int unsigned BLINK_FRAMES = 2;
    localparam int unsigned FRAME        = SCAN_DIV * DIGITS;

    logic        Clk;
    logic        Reset_n;
    logic [15:0] Disp_Data;
    logic [3:0]  Dp_Mask, Blank_Mask, Blink_Mask, Bright;
    logic        Lz_En, Load;
    logic [3:0]  SEL;
    logic [7:0]  SEG;
    logic        Frame_Done;

    int checks = 0;
    int errors = 0;

    seg_scan_ctrl #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES),
        .SEL_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(1)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Disp_Data(Disp_Data), .Dp_Mask(Dp_Mask),
        .Blank_Mask(Blank_Mask), .Blink_Mask(Blink_Mask), .Bright(Bright),
        .Lz_En(Lz_En), .Load(Load), .SEL(SEL), .SEG(SEG), .Frame_Done(Frame_Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [6:0] hex_tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Reference model: t = counter state (cycles since reset release)
    int          t;
    logic [15:0] m_sh_data,  m_act_data;
    logic [3:0]  m_sh_dp,    m_act_dp;
    logic [3:0]  m_sh_blank, m_act_blank;
    logic [3:0]  m_sh_blink, m_act_blink;
    logic [3:0]  m_sh_bright, m_act_bright;
    logic        m_sh_lz,    m_act_lz;

    task automatic model_reset();
        t = 0;
        m_sh_data = '0;  m_act_data = '0;
        m_sh_dp = '0;    m_act_dp = '0;
        m_sh_blank = '1; m_act_blank = '1;
        m_sh_blink = '0; m_act_blink = '0;
        m_sh_bright = '0; m_act_bright = '0;
        m_sh_lz = 1'b0;  m_act_lz = 1'b0;
    endtask

    function automatic int cur_slot();
        return t % SCAN_DIV;
    endfunction

    function automatic int cur_digit();
        return (t / SCAN_DIV) % DIGITS;
    endfunction

    task automatic model_out(output logic [3:0] esel, output logic [7:0] eseg, output logic efd);
        int          slot, d, frame;
        logic        ph, supp, dark;
        logic [15:0] hi;
        slot  = cur_slot();
        d     = cur_digit();
        frame = t / FRAME;
        ph    = ((frame / BLINK_FRAMES) % 2) == 1;
        hi    = m_act_data >> (4 * d);
        supp  = m_act_lz && (d > 0) && (hi == 16'h0);
        dark  = (slot == 0) || m_act_blank[d] || supp || (m_act_blink[d] && ph)
             || ((slot / (SCAN_DIV / 16)) > int'(m_act_bright));
        if (dark) begin
            esel = 4'h0;
            eseg = 8'hFF;
        end else begin
            esel = 4'(1) << d;
            eseg = ~{m_act_dp[d], hex_tbl[hi[3:0]]};
        end
        efd = (slot == SCAN_DIV - 1) && (d == DIGITS - 1);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", name, act, exp, t, $time);
        end
    endtask

    // One clock: predict, advance, update model, compare every output
    task automatic step();
        logic [3:0] es;
        logic [7:0] eg;
        logic       ef;
        model_out(es, eg, ef);
        @(posedge Clk);
        #1;
        if (ef) begin
            m_act_data   = Load ? Disp_Data  : m_sh_data;
            m_act_dp     = Load ? Dp_Mask    : m_sh_dp;
            m_act_blank  = Load ? Blank_Mask : m_sh_blank;
            m_act_blink  = Load ? Blink_Mask : m_sh_blink;
            m_act_bright = Load ? Bright     : m_sh_bright;
            m_act_lz     = Load ? Lz_En      : m_sh_lz;
        end
        if (Load) begin
            m_sh_data = Disp_Data;  m_sh_dp = Dp_Mask;   m_sh_blank = Blank_Mask;
            m_sh_blink = Blink_Mask; m_sh_bright = Bright; m_sh_lz = Lz_En;
        end
        t++;
        check("scan", {19'h0, SEL, SEG, Frame_Done}, {19'h0, es, eg, ef});
    endtask

    // Step until the counter state is (digit d, slot s), bounded
    task automatic seek(input int d, input int s);
        int n;
        n = 0;
        while (!(cur_digit() == d && cur_slot() == s) && n < 2 * FRAME) begin
            step();
            n++;
        end
        if (n >= 2 * FRAME) check("seek_bound", 32'(n), 32'(2 * FRAME - 1));
    endtask

    task automatic seek_frame_start();
        int n;
        n = 0;
        while ((t % FRAME) != 0 && n < 2 * FRAME) begin
            step();
            n++;
        end
        if (n >= 2 * FRAME) check("frame_bound", 32'(n), 32'(2 * FRAME - 1));
    endtask

    task automatic set_inputs(input logic [15:0] data, input logic [3:0] dp, input logic [3:0] blank,
                              input logic [3:0] blink, input logic [3:0] br, input logic lz);
        Disp_Data = data; Dp_Mask = dp; Blank_Mask = blank;
        Blink_Mask = blink; Bright = br; Lz_En = lz;
    endtask

    // Load inputs then run until they are on the display
    task automatic commit(input logic [15:0] data, input logic [3:0] dp, input logic [3:0] blank,
                          input logic [3:0] blink, input logic [3:0] br, input logic lz);
        set_inputs(data, dp, blank, blink, br, lz);
        Load = 1'b1;
        step();
        Load = 1'b0;
        seek_frame_start();
    endtask

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  bright;
        logic        lz;
        int          d;
        int          s;
        logic [3:0]  esel;
        logic [7:0]  eseg;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    int   fd_count;
    int   lit_count;
    logic exp_lit;

    initial begin
        vecs[0]  = '{16'h12AF, 4'h0, 4'h0, 4'hF, 1'b0, 0,  5, 4'b0001, 8'h8E};
        vecs[1]  = '{16'h12AF, 4'h0, 4'h0, 4'hF, 1'b0, 1, 31, 4'b0010, 8'h88};
        vecs[2]  = '{16'h12AF, 4'h0, 4'h0, 4'hF, 1'b0, 2, 16, 4'b0100, 8'hA4};
        vecs[3]  = '{16'h12AF, 4'h0, 4'h0, 4'hF, 1'b0, 3,  1, 4'b1000, 8'hF9};
        vecs[4]  = '{16'h12AF, 4'h0, 4'h0, 4'hF, 1'b0, 0,  0, 4'b0000, 8'hFF};
        vecs[5]  = '{16'h12AF, 4'h0, 4'h0, 4'h3, 1'b0, 1,  7, 4'b0010, 8'h88};
        vecs[6]  = '{16'h12AF, 4'h0, 4'h0, 4'h3, 1'b0, 1,  8, 4'b0000, 8'hFF};
        vecs[7]  = '{16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0, 2,  1, 4'b0100, 8'hA4};
        vecs[8]  = '{16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0, 2,  2, 4'b0000, 8'hFF};
        vecs[9]  = '{16'h0050, 4'h0, 4'h0, 4'hF, 1'b1, 3, 10, 4'b0000, 8'hFF};
        vecs[10] = '{16'h0050, 4'h0, 4'h0, 4'hF, 1'b1, 2, 10, 4'b0000, 8'hFF};
        vecs[11] = '{16'h0050, 4'h0, 4'h0, 4'hF, 1'b1, 1, 10, 4'b0010, 8'h92};
        vecs[12] = '{16'h0050, 4'h0, 4'h0, 4'hF, 1'b1, 0, 10, 4'b0001, 8'hC0};
        vecs[13] = '{16'h0000, 4'h0, 4'h0, 4'hF, 1'b1, 0,  3, 4'b0001, 8'hC0};
        vecs[14] = '{16'h0000, 4'h0, 4'h0, 4'hF, 1'b1, 1,  3, 4'b0000, 8'hFF};
        vecs[15] = '{16'h12AF, 4'h2, 4'h0, 4'hF, 1'b0, 1,  4, 4'b0010, 8'h08};
        vecs[16] = '{16'h12AF, 4'h0, 4'h4, 4'hF, 1'b0, 2,  4, 4'b0000, 8'hFF};
        vecs[17] = '{16'h0050, 4'h0, 4'h0, 4'hF, 1'b0, 3,  4, 4'b1000, 8'hC0};

        Reset_n = 1'b0;
        Load    = 1'b0;
        set_inputs(16'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("reset_state", {20'h0, SEL, SEG, Frame_Done}, {20'h0, 4'h0, 8'hFF, 1'b0});
        Reset_n = 1'b1;

        // Dark for three frames with no Load; one Frame_Done per frame
        fd_count = 0;
        for (int i = 0; i < 3 * int'(FRAME); i++) begin
            step();
            if (Frame_Done) fd_count++;
        end
        check("fd_count_3frames", 32'(fd_count), 32'd3);

        // Vector table
        for (int v = 0; v < NVEC; v++) begin
            commit(vecs[v].data, vecs[v].dp, vecs[v].blank, 4'h0, vecs[v].bright, vecs[v].lz);
            seek(vecs[v].d, vecs[v].s);
            step();
            check($sformatf("vec%0d", v), {20'h0, SEL, SEG}, {20'h0, vecs[v].esel, vecs[v].eseg});
        end

        // Blink: digit0 alternates in pairs of frames, digit1 steady
        commit(16'h12AF, 4'h0, 4'h0, 4'h1, 4'hF, 1'b0);
        lit_count = 0;
        for (int f = 0; f < 4; f++) begin
            seek(0, 5);
            exp_lit = (((t / FRAME) / BLINK_FRAMES) % 2) == 0;
            step();
            if (SEL == 4'b0001) lit_count++;
            check("blink_d0", {31'h0, SEL == 4'b0001}, {31'h0, exp_lit});
            seek(1, 5);
            step();
            check("blink_d1", {24'h0, SEL, 4'h0}, {24'h0, 4'b0010, 4'h0});
        end
        check("blink_lit_frames", 32'(lit_count), 32'd2);

        // Load mid-frame: old data stays until frame end
        commit(16'h1111, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0);
        seek(1, 10);
        Disp_Data = 16'h2222;
        Load = 1'b1;
        step();
        Load = 1'b0;
        seek(2, 5);
        step();
        check("midload_old_d2", {24'h0, SEG}, {24'h0, 8'hF9});
        seek(3, 5);
        step();
        check("midload_old_d3", {24'h0, SEG}, {24'h0, 8'hF9});
        seek(0, 5);
        step();
        check("midload_new_d0", {24'h0, SEG}, {24'h0, 8'hA4});

        // Load coincident with frame end: new data in the very next frame
        seek(3, 31);
        Disp_Data = 16'h3333;
        Load = 1'b1;
        step();
        Load = 1'b0;
        seek(0, 5);
        step();
        check("fe_load_d0", {24'h0, SEG}, {24'h0, 8'hB0});

        // Reset mid-slot: outputs go inactive without waiting for a clock
        seek(2, 10);
        step();
        check("pre_reset_lit", {28'h0, SEL}, {28'h0, 4'b0100});
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_reset", {20'h0, SEL, SEG, Frame_Done}, {20'h0, 4'h0, 8'hFF, 1'b0});
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < int'(FRAME) + 5; i++) step();
        check("post_reset_dark", {24'h0, SEG}, {24'h0, 8'hFF});

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            set_inputs(16'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom),
                       4'($urandom) & 4'($urandom), 4'($urandom), 1'($urandom));
            if (($urandom % 8) == 0) Disp_Data = Disp_Data & 16'h00FF;
            Load = (($urandom % 24) == 0);
            step();
        end
        Load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Parametrised multiplexed 7-segment display controller. It is the successor to the fixed 8-digit hex scanner: digit count, scan rate and pin polarity are configurable. It adds double-buffered frame-synchronous update, per-digit decimal point, blanking and blink masks, 16-level PWM brightness, and leading-zero suppression. It sits between the clock/time-keeping datapath and the board's SEL/SEG pins.

Parameters:
DIGITS, 8, number of digits scanned (2..16)
SCAN_DIV, 50_000, Clk cycles per digit slot; must be a multiple of 16
BLINK_FRAMES, 250, full frames per blink half-period
SEL_ACTIVE_LOW, 0, 1 = SEL pins active-low
SEG_ACTIVE_LOW, 1, 1 = SEG pins active-low

Ports:
Clk  in  1  system clock
Reset_n  in  1  reset
Disp_Data  in  4*DIGITS  nibble i drives digit i; digit 0 is least significant
Dp_Mask  in  DIGITS  bit i lights the decimal point of digit i
Blank_Mask  in  DIGITS  bit i forces digit i dark
Blink_Mask  in  DIGITS  bit i makes digit i blink
Bright  in  4  duty = (Bright+1)/16 of each slot
Lz_En  in  1  leading-zero suppression enable
Load  in  1  one-cycle strobe; captures all display inputs into the shadow set
SEL  out  DIGITS  one-hot digit enable, polarity per SEL_ACTIVE_LOW
SEG  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
Frame_Done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Reset: Clk, with Reset_n asynchronous and active-low. While reset is asserted, SEL and SEG are all inactive and Frame_Done=0. All counters are 0. Shadow and active registers are 0, except Blank_Mask, which resets to all ones so the display stays dark until the first commit.
- Counters:
  - slot_cnt runs 0..SCAN_DIV-1.
  - digit_idx increments when slot_cnt wraps and wraps DIGITS-1 -> 0.
  - frame_cnt runs 0..BLINK_FRAMES-1; at each wrap, blink_ph toggles.
- Frame end (fe): slot_cnt==SCAN_DIV-1 && digit_idx==DIGITS-1.
  - Frame_Done is registered and goes high on the cycle after fe, for exactly 1 cycle.
- Double buffering:
  - Load=1 copies all inputs into the shadow set.
  - On the fe edge, the active set takes the shadow set.
  - If Load and fe coincide, the active set takes the live inputs directly, and the shadow is updated too.
  - Display content never changes mid-frame.
- PWM: phase = slot_cnt / (SCAN_DIV/16), range 0..15. The digit is lit when phase <= Bright_active. Bright=15 gives full on; Bright=0 gives 1/16 duty.
- Leading-zero suppression: when Lz_En is set, digit i (i>0) is suppressed if it and every higher nibble are 0. Digit 0 is never suppressed. Dp does not count as non-zero.
- Dark condition: dark = Blank[i] | suppressed(i) | (Blink[i] & blink_ph) | (phase > Bright).
  - If dark: SEL all inactive and SEG all inactive.
  - Otherwise: SEL = onehot(digit_idx); SEG = {Dp[i], hexseg(nibble)}.
- Latency: SEL and SEG are registered, 1 cycle after the counter state that produces them.
- Switching: SEL and SEG change on the same edge. The first cycle of every slot (slot_cnt==0) is forced dark as an anti-ghosting dead time.
- hexseg, active-high {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Polarity inversion is applied last, at the output register.
- Reset mid-scan: everything returns to reset values immediately (asynchronous). The scan restarts at digit 0 and the display stays dark until the first commit.

Decomposition:
- Package seg_pkg holds:
  - segment bit-position constants
  - the 16-entry hexseg constant table
  - the DP bit index
- Sub-module seg_hex_decode: combinational 4-bit -> 7-bit decode. It is reused by other display blocks.

Test Plan (DIGITS=4, SCAN_DIV=32, BLINK_FRAMES=2, SEG_ACTIVE_LOW=1, SEL_ACTIVE_LOW=0):
- Reset, no Load -> SEL=0000 and SEG=FF for 3 full frames; Frame_Done pulses every 128 cycles.
- Load Disp_Data=16'h12AF, masks 0, Bright=15 -> after the next fe:
  - digit0 SEG=8E
  - digit1 SEG=88
  - digit2 SEG=A4
  - digit3 SEG=F9
  - SEL one-hot, lit 31 of 32 cycles per slot
- Bright=3 -> each slot lit only for slot_cnt 1..7 and dark for slot_cnt 0 and 8..31.
- Lz_En=1, Disp_Data=16'h0050 -> digits 3 and 2 dark, digit1=92, digit0=C0. With Data=0000, only digit0 is lit (C0).
- Blink_Mask=0001 -> digit0 lit for 2 frames, dark for 2 frames, repeating; the other digits are unaffected. Dp_Mask=0010 -> digit1 SEG bit7=0.
- Load asserted mid-frame with new data -> the old value persists until fe. Load coincident with fe -> the new data appears in the very next frame. Reset_n pulsed mid-slot -> SEL/SEG are inactive immediately.
